// File: rtl/complex_divider.sv
// Complex divider: q = (x + jy) / (c + jd), computed as two parallel restoring divisions of
// the real and imaginary numerator magnitudes by D = c*c + d*d, one quotient bit per cycle.
// Results are truncated toward zero and saturated to signed 8 bits; D = 0 yields 0x7F7F
// with DivZero set.
module complex_divider (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        InValid,
  output logic        InReady,
  input  logic [33:0] Dividend,
  input  logic [15:0] Divisor,
  output logic        OutValid,
  input  logic        OutReady,
  output logic [15:0] Quotient,
  output logic        DivZero
);

  typedef enum logic [1:0] {StIdle, StPrep, StDiv, StDone} state_e;

  localparam logic [4:0] LastIter = 5'd24;

  state_e state_q, state_d;

  // Captured operands
  logic signed [16:0] x_q, y_q;
  logic signed [7:0]  c_q, d_q;

  // PREP takes two cycles: products first, then magnitudes/signs from the registered
  // numerators, so the D = 0 decision also works from a registered D.
  logic               prep_q;

  logic signed [25:0] num_re_q, num_im_q;
  logic [15:0]        den_q;
  logic               neg_re_q, neg_im_q;
  logic [24:0]        sh_re_q, sh_im_q;
  logic [15:0]        rem_re_q, rem_im_q;
  logic [24:0]        quo_re_q, quo_im_q;
  logic [4:0]         count_q;
  logic [15:0]        quotient_q;
  logic               div_zero_q;

  // Numerator / denominator arithmetic on the captured operands
  logic signed [25:0] xe, ye, ce, de;
  logic signed [25:0] nr_c, ni_c;
  logic signed [15:0] c16, d16;
  logic [15:0]        den_c;
  logic [24:0]        mag_re_c, mag_im_c;

  // Products and magnitudes; magnitudes need 25 bits since |num| can reach exactly 2^24
  always_comb begin
    xe    = {{9{x_q[16]}}, x_q};
    ye    = {{9{y_q[16]}}, y_q};
    ce    = {{18{c_q[7]}}, c_q};
    de    = {{18{d_q[7]}}, d_q};
    nr_c  = xe * ce + ye * de;
    ni_c  = ye * ce - xe * de;
    c16   = {{8{c_q[7]}}, c_q};
    d16   = {{8{d_q[7]}}, d_q};
    den_c = c16 * c16 + d16 * d16;
    mag_re_c = num_re_q[25] ? (~num_re_q[24:0] + 25'd1) : num_re_q[24:0];
    mag_im_c = num_im_q[25] ? (~num_im_q[24:0] + 25'd1) : num_im_q[24:0];
  end

  // One restoring-division step for each part
  logic [16:0] trial_re, trial_im, diff_re, diff_im;
  logic        ge_re, ge_im;
  logic [15:0] rem_re_c, rem_im_c;
  logic [24:0] quo_re_c, quo_im_c;

  // Shift in the next numerator bit, subtract D when it fits
  always_comb begin
    trial_re = {rem_re_q, sh_re_q[24]};
    trial_im = {rem_im_q, sh_im_q[24]};
    diff_re  = trial_re - {1'b0, den_q};
    diff_im  = trial_im - {1'b0, den_q};
    ge_re    = trial_re >= {1'b0, den_q};
    ge_im    = trial_im >= {1'b0, den_q};
    rem_re_c = ge_re ? diff_re[15:0] : trial_re[15:0];
    rem_im_c = ge_im ? diff_im[15:0] : trial_im[15:0];
    quo_re_c = {quo_re_q[23:0], ge_re};
    quo_im_c = {quo_im_q[23:0], ge_im};
  end

  // Apply sign to an unsigned magnitude and clamp to [-128, 127]
  function automatic logic [7:0] sat_q(input logic neg, input logic [24:0] mag);
    logic [7:0] r;
    if (mag == 25'd0) begin
      r = 8'h00;
    end else if (!neg) begin
      r = (mag > 25'd127) ? 8'h7F : mag[7:0];
    end else begin
      r = (mag > 25'd128) ? 8'h80 : (~mag[7:0] + 8'd1);
    end
    return r;
  endfunction

  // State register
  always_ff @(posedge Clk) begin
    if (Reset) state_q <= StIdle;
    else       state_q <= state_d;
  end

  // Next state and handshake outputs
  always_comb begin
    state_d  = state_q;
    InReady  = 1'b0;
    OutValid = 1'b0;
    case (state_q)
      StIdle: begin
        InReady = 1'b1;
        if (InValid) state_d = StPrep;
      end
      StPrep: begin
        if (prep_q) state_d = (den_q == 16'd0) ? StDone : StDiv;
      end
      StDiv: begin
        if (count_q == LastIter) state_d = StDone;
      end
      StDone: begin
        OutValid = 1'b1;
        if (OutReady) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // Datapath: capture, prepare, iterate, register the signed saturated result
  always_ff @(posedge Clk) begin
    if (Reset) begin
      x_q        <= '0;
      y_q        <= '0;
      c_q        <= '0;
      d_q        <= '0;
      prep_q     <= 1'b0;
      num_re_q   <= '0;
      num_im_q   <= '0;
      den_q      <= '0;
      neg_re_q   <= 1'b0;
      neg_im_q   <= 1'b0;
      sh_re_q    <= '0;
      sh_im_q    <= '0;
      rem_re_q   <= '0;
      rem_im_q   <= '0;
      quo_re_q   <= '0;
      quo_im_q   <= '0;
      count_q    <= '0;
      quotient_q <= '0;
      div_zero_q <= 1'b0;
    end else begin
      case (state_q)
        StIdle: begin
          prep_q <= 1'b0;
          if (InValid) begin
            x_q <= Dividend[33:17];
            y_q <= Dividend[16:0];
            c_q <= Divisor[15:8];
            d_q <= Divisor[7:0];
          end
        end
        StPrep: begin
          if (!prep_q) begin
            num_re_q <= nr_c;
            num_im_q <= ni_c;
            den_q    <= den_c;
            prep_q   <= 1'b1;
          end else begin
            neg_re_q <= num_re_q[25];
            neg_im_q <= num_im_q[25];
            sh_re_q  <= mag_re_c;
            sh_im_q  <= mag_im_c;
            rem_re_q <= '0;
            rem_im_q <= '0;
            quo_re_q <= '0;
            quo_im_q <= '0;
            count_q  <= '0;
            prep_q   <= 1'b0;
            if (den_q == 16'd0) begin
              quotient_q <= 16'h7F7F;
              div_zero_q <= 1'b1;
            end
          end
        end
        StDiv: begin
          sh_re_q  <= {sh_re_q[23:0], 1'b0};
          sh_im_q  <= {sh_im_q[23:0], 1'b0};
          rem_re_q <= rem_re_c;
          rem_im_q <= rem_im_c;
          quo_re_q <= quo_re_c;
          quo_im_q <= quo_im_c;
          count_q  <= count_q + 5'd1;
          if (count_q == LastIter) begin
            quotient_q <= {sat_q(neg_re_q, quo_re_c), sat_q(neg_im_q, quo_im_c)};
            div_zero_q <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  assign Quotient = quotient_q;
  assign DivZero  = div_zero_q;

endmodule

// File: tb/tb_complex_divider.sv
// Self-checking bench for complex_divider: directed cases plus random operands, all checked
// against an integer-arithmetic model of the complex quotient.
module tb_complex_divider;

  logic        Clk = 1'b0;
  logic        Reset = 1'b1;
  logic        InValid = 1'b0;
  logic        InReady;
  logic [33:0] Dividend = '0;
  logic [15:0] Divisor = '0;
  logic        OutValid;
  logic        OutReady = 1'b0;
  logic [15:0] Quotient;
  logic        DivZero;

  int n_cmp = 0;
  int n_err = 0;

  complex_divider dut (
    .Clk      (Clk),
    .Reset    (Reset),
    .InValid  (InValid),
    .InReady  (InReady),
    .Dividend (Dividend),
    .Divisor  (Divisor),
    .OutValid (OutValid),
    .OutReady (OutReady),
    .Quotient (Quotient),
    .DivZero  (DivZero)
  );

  always #5 Clk = ~Clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] clamp8(input int v);
    int r;
    r = (v > 127) ? 127 : ((v < -128) ? -128 : v);
    return 8'(r);
  endfunction

  // Reference: exact complex quotient with C-style truncating integer division
  task automatic model(input int x, input int y, input int c, input int d,
                       output logic [15:0] q, output logic dz);
    int nr, ni, den;
    nr  = x * c + y * d;
    ni  = y * c - x * d;
    den = c * c + d * d;
    if (den == 0) begin
      q  = 16'h7F7F;
      dz = 1'b1;
    end else begin
      q  = {clamp8(nr / den), clamp8(ni / den)};
      dz = 1'b0;
    end
  endtask

  task automatic drive(input int x, input int y, input int c, input int d);
    logic [16:0] xs, ys;
    logic [7:0]  cs, ds;
    xs = 17'(x);
    ys = 17'(y);
    cs = 8'(c);
    ds = 8'(d);
    Dividend = {xs, ys};
    Divisor  = {cs, ds};
  endtask

  task automatic wait_ready(input string tag);
    int n;
    n = 0;
    while (!InReady && n < 100) begin
      @(posedge Clk); #1;
      n++;
    end
    check({tag, "_ready"}, 32'(InReady), 32'd1);
  endtask

  // From just after the accepting edge: wait for the result, check it, then handshake
  task automatic finish_op(input string tag, input logic [15:0] eq, input logic edz);
    int lat;
    lat = 0;
    while (!OutValid && lat < 60) begin
      @(posedge Clk); #1;
      lat++;
    end
    check({tag, "_latency"}, 32'(lat), edz ? 32'd2 : 32'd27);
    check({tag, "_quotient"}, 32'(Quotient), 32'(eq));
    check({tag, "_divzero"}, 32'(DivZero), 32'(edz));
    OutReady = 1'b1;
    @(posedge Clk); #1;
    OutReady = 1'b0;
    check({tag, "_outvalid_clr"}, 32'(OutValid), 32'd0);
  endtask

  task automatic run_op(input string tag, input int x, input int y, input int c, input int d);
    logic [15:0] eq;
    logic        edz;
    model(x, y, c, d, eq, edz);
    wait_ready(tag);
    drive(x, y, c, d);
    InValid = 1'b1;
    @(posedge Clk); #1;
    InValid = 1'b0;
    check({tag, "_inready_busy"}, 32'(InReady), 32'd0);
    finish_op(tag, eq, edz);
  endtask

  initial begin
    logic [15:0] eq, eq2;
    logic        edz, edz2;
    int          seen;
    int          x, y, c, d;

    // Reset wins over simultaneous InValid/OutReady
    Reset = 1'b1;
    InValid = 1'b1;
    OutReady = 1'b1;
    drive(3, 3, 1, 1);
    repeat (3) @(posedge Clk);
    #1;
    Reset = 1'b0;
    InValid = 1'b0;
    OutReady = 1'b0;
    check("rst_inready", 32'(InReady), 32'd1);
    check("rst_outvalid", 32'(OutValid), 32'd0);
    check("rst_quotient", 32'(Quotient), 32'd0);
    check("rst_divzero", 32'(DivZero), 32'd0);

    // Directed cases
    run_op("exact", -5, 10, 1, 2);
    check("exact_const", 32'(Quotient), 32'h0304);
    run_op("trunc_pos", 7, 0, 2, 0);
    check("trunc_pos_const", 32'(Quotient), 32'h0300);
    run_op("trunc_neg", -7, 0, 2, 0);
    check("trunc_neg_const", 32'(Quotient), 32'hFD00);
    run_op("sat_pos", 1000, 0, 1, 0);
    check("sat_pos_const", 32'(Quotient), 32'h7F00);
    run_op("sat_neg", -1000, 0, 1, 0);
    check("sat_neg_const", 32'(Quotient), 32'h8000);
    // Extremes: x = y = -65536, c = d = -128; imaginary numerator cancels to zero
    run_op("extreme_a", -65536, -65536, -128, -128);
    // Extremes with negative imaginary saturation
    run_op("extreme_b", -65536, 65535, -128, -128);
    run_op("extreme_c", -65536, 0, -128, 0);
    run_op("divzero", 12345, -999, 0, 0);
    check("divzero_const", 32'(Quotient), 32'h7F7F);

    // Backpressure in DONE with ignored InValid pulses
    model(-5, 10, 1, 2, eq, edz);
    wait_ready("bp");
    drive(-5, 10, 1, 2);
    InValid = 1'b1;
    @(posedge Clk); #1;
    InValid = 1'b0;
    seen = 0;
    while (!OutValid && seen < 60) begin
      @(posedge Clk); #1;
      seen++;
    end
    check("bp_latency", 32'(seen), 32'd27);
    for (int k = 0; k < 5; k++) begin
      InValid = (k % 2 == 0);
      drive(100, 100, 1, 1);
      @(posedge Clk); #1;
      check("bp_hold_quotient", 32'(Quotient), 32'(eq));
      check("bp_hold_outvalid", 32'(OutValid), 32'd1);
      check("bp_hold_inready", 32'(InReady), 32'd0);
    end
    // Handshake edge with a new operand already presented: accepted only on the next edge
    model(7, 0, 2, 0, eq2, edz2);
    drive(7, 0, 2, 0);
    InValid = 1'b1;
    OutReady = 1'b1;
    @(posedge Clk); #1;
    OutReady = 1'b0;
    check("bp_release_outvalid", 32'(OutValid), 32'd0);
    check("bp_release_inready", 32'(InReady), 32'd1);
    @(posedge Clk); #1;
    InValid = 1'b0;
    check("bp_next_accepted", 32'(InReady), 32'd0);
    finish_op("bp_next", eq2, edz2);

    // Reset while the divider is on iteration 10
    wait_ready("middiv");
    drive(1000, -2000, 3, 4);
    InValid = 1'b1;
    @(posedge Clk); #1;
    InValid = 1'b0;
    repeat (12) @(posedge Clk);
    #1;
    Reset = 1'b1;
    @(posedge Clk); #1;
    Reset = 1'b0;
    check("middiv_inready", 32'(InReady), 32'd1);
    check("middiv_outvalid", 32'(OutValid), 32'd0);
    check("middiv_quotient", 32'(Quotient), 32'd0);
    seen = 0;
    for (int k = 0; k < 30; k++) begin
      @(posedge Clk); #1;
      if (OutValid) seen++;
    end
    check("middiv_no_result", 32'(seen), 32'd0);
    run_op("after_reset", 1000, -2000, 3, 4);

    // Random operands across small and full ranges
    for (int i = 0; i < 24; i++) begin
      if (i % 3 == 1) begin
        x = int'($urandom_range(0, 4000)) - 2000;
        y = int'($urandom_range(0, 4000)) - 2000;
        c = int'($urandom_range(0, 40)) - 20;
        d = int'($urandom_range(0, 40)) - 20;
      end else begin
        x = int'($urandom_range(0, 131071)) - 65536;
        y = int'($urandom_range(0, 131071)) - 65536;
        c = int'($urandom_range(0, 255)) - 128;
        d = int'($urandom_range(0, 255)) - 128;
      end
      if (i % 8 == 7) begin
        c = 0;
        d = 0;
      end
      run_op($sformatf("rand%0d", i), x, y, c, d);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
